ula_result_fifo: RTL

ULA_RESULT_FIFO -- requirements
Module: ula_result_fifo

---
 rtl/ula_result_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/ula_result_fifo.sv
// ---------------------------------------------------------------------------
// ula_result_fifo
// Small first-word fall-through FIFO that buffers ULA results together with
// their zero/sign flags and the selector tag that produced them.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous flush (pointers, count, overflow), beats push/pop
//   in_valid     producer offers an entry
//   in_ready     FIFO not full (never depends on out_ready)
//   in_result    ULA result word
//   in_zero      ULA zero flag
//   in_sign      ULA sign flag
//   in_sel       ULA selector tag
//   out_valid    head entry present
//   out_ready    consumer takes the head entry
//   out_result   head result   (0 when empty)
//   out_zero     head zero flag (0 when empty)
//   out_sign     head sign flag (0 when empty)
//   out_sel      head tag       (0 when empty)
//   count        number of stored entries
//   overflow     sticky: a push was offered while full
// ---------------------------------------------------------------------------
module ula_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_result,
  input  logic                   in_zero,
  input  logic                   in_sign,
  input  logic [3:0]             in_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_result,
  output logic                   out_zero,
  output logic                   out_sign,
  output logic [3:0]             out_sel,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = W + 6;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // Flow control comes only from registered count, so in_ready has no
  // combinational path from out_ready; a pop while full reopens it next cycle.
  assign w_full    = (r_count == FULL_CNT);
  assign in_ready  = !w_full;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && !w_full;
  assign w_pop     = out_valid && out_ready;

  // Fall-through head: asynchronous read at the read pointer, masked to zero
  // while empty so stale storage never leaks out (also during reset).
  assign w_head     = r_mem[r_rptr];
  assign out_result = out_valid ? w_head[W-1:0] : '0;
  assign out_zero   = out_valid ? w_head[W]     : 1'b0;
  assign out_sign   = out_valid ? w_head[W+1]   : 1'b0;
  assign out_sel    = out_valid ? w_head[W+5:W+2] : 4'd0;
  assign count      = r_count;
  assign overflow   = r_overflow;

  // Storage is not reset; only a push into a free slot writes it.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wptr] <= {in_sel, in_sign, in_zero, in_result};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointers are exactly PW bits, so the increment wraps DEPTH-1 -> 0.
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
